// File: rtl/serial_pkg.sv
// Shared definitions for the framed serial transmitter and its matching receiver.
package serial_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_e;

  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/bit_timer.sv
// Bit-period timer: pulses bit_done on the last clock of every CLKS_PER_BIT-clock period while run=1.
module bit_timer #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  output logic bit_done
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Counter sits at zero whenever run drops, so each new frame starts a fresh period.
  always_comb begin
    cnt_d    = '0;
    bit_done = 1'b0;
    if (run) begin
      if (cnt_q == LAST) begin
        bit_done = 1'b1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/serial_frame_tx.sv
// Parallel-in, serial-out framed transmitter: start(0), data LSB first, optional even parity, stop(1).
module serial_frame_tx
  import serial_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4,
  parameter int PARITY_EN    = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              tx_out,
  output logic              tx_busy
);

  localparam int BCW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [BCW-1:0] LAST_BIT = BCW'(DATA_W - 1);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [BCW-1:0]    bit_cnt_q, bit_cnt_d;
  logic              par_q, par_d;
  logic              tx_q, tx_d;
  logic              timer_run;
  logic              bit_done;
  logic              accept;

  assign timer_run = (state_q != IDLE);
  assign accept    = tx_valid && (state_q == IDLE);

  bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk     (clk),
    .reset   (reset),
    .run     (timer_run),
    .bit_done(bit_done)
  );

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    par_d     = par_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = START;
          shreg_d = tx_data;
          par_d   = ^tx_data;
        end
      end
      START: begin
        if (bit_done) state_d = DATA;
      end
      DATA: begin
        if (bit_done) begin
          shreg_d = shreg_q >> 1;
          if (bit_cnt_q == LAST_BIT) begin
            bit_cnt_d = '0;
            state_d   = (PARITY_EN != 0) ? PARITY : STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + BCW'(1);
          end
        end
      end
      PARITY: begin
        if (bit_done) state_d = STOP;
      end
      STOP: begin
        if (bit_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Line level is derived from the upcoming state so the output flop changes with the state.
  always_comb begin
    tx_d = LINE_IDLE;
    case (state_d)
      IDLE:    tx_d = LINE_IDLE;
      START:   tx_d = START_BIT;
      DATA:    tx_d = shreg_d[0];
      PARITY:  tx_d = par_d;
      STOP:    tx_d = STOP_BIT;
      default: tx_d = LINE_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      par_q     <= 1'b0;
      tx_q      <= LINE_IDLE;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      par_q     <= par_d;
      tx_q      <= tx_d;
    end
  end

  assign tx_out   = tx_q;
  assign tx_ready = (state_q == IDLE);
  assign tx_busy  = (state_q != IDLE);

endmodule

// File: tb/tb_serial_frame_tx.sv
// Bench for serial_frame_tx: three configurations checked against a frame-level line model.
module tb_serial_frame_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic [7:0] a_data, b_data;
  logic [3:0] c_data;
  logic       a_valid, b_valid, c_valid;
  logic       a_ready, a_out, a_busy;
  logic       b_ready, b_out, b_busy;
  logic       c_ready, c_out, c_busy;

  serial_frame_tx #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY_EN(0)) dut_a (
    .clk(clk), .reset(reset), .tx_data(a_data), .tx_valid(a_valid),
    .tx_ready(a_ready), .tx_out(a_out), .tx_busy(a_busy));

  serial_frame_tx #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY_EN(1)) dut_b (
    .clk(clk), .reset(reset), .tx_data(b_data), .tx_valid(b_valid),
    .tx_ready(b_ready), .tx_out(b_out), .tx_busy(b_busy));

  serial_frame_tx #(.DATA_W(4), .CLKS_PER_BIT(1), .PARITY_EN(0)) dut_c (
    .clk(clk), .reset(reset), .tx_data(c_data), .tx_valid(c_valid),
    .tx_ready(c_ready), .tx_out(c_out), .tx_busy(c_busy));

  int   n_cmp = 0;
  int   n_fail = 0;
  int   sel = 0;
  logic m_out, m_busy, m_ready;
  bit   exp_q[$];

  always_comb begin
    case (sel)
      1:       begin m_out = b_out; m_busy = b_busy; m_ready = b_ready; end
      2:       begin m_out = c_out; m_busy = c_busy; m_ready = c_ready; end
      default: begin m_out = a_out; m_busy = a_busy; m_ready = a_ready; end
    endcase
  end

  task automatic drive(input int s, input logic v, input logic [15:0] d);
    case (s)
      1:       begin b_valid = v; b_data = d[7:0]; end
      2:       begin c_valid = v; c_data = d[3:0]; end
      default: begin a_valid = v; a_data = d[7:0]; end
    endcase
  endtask

  // Expected line level for every clock of one frame, built from the framing rules.
  function automatic void model_frame(input logic [15:0] d, input int dw, input int cpb, input int par);
    int ones;
    bit b;
    ones = 0;
    exp_q.delete();
    for (int i = 0; i < cpb; i++) exp_q.push_back(1'b0);
    for (int k = 0; k < dw; k++) begin
      b = d[k];
      if (b) ones++;
      for (int i = 0; i < cpb; i++) exp_q.push_back(b);
    end
    if (par != 0) begin
      b = ((ones % 2) == 1);
      for (int i = 0; i < cpb; i++) exp_q.push_back(b);
    end
    for (int i = 0; i < cpb; i++) exp_q.push_back(1'b1);
  endfunction

  // Entered one time unit after a rising edge with the selected DUT idle.
  task automatic tx_frame(input int s, input logic [15:0] d, input int dw, input int cpb,
                          input int par, input string tag);
    sel = s;
    model_frame(d, dw, cpb, par);
    drive(s, 1'b1, d);
    @(posedge clk); #1;
    drive(s, 1'b0, 16'($urandom));
    foreach (exp_q[i]) begin
      n_cmp++;
      if (m_out !== exp_q[i] || m_busy !== 1'b1 || m_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL %s clk %0d: out/busy/ready=%b%b%b required %b10", tag, i, m_out, m_busy, m_ready, exp_q[i]);
      end
      @(posedge clk); #1;
    end
    n_cmp++;
    if (m_out !== 1'b1 || m_busy !== 1'b0 || m_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s end-idle: out/busy/ready=%b%b%b required 101", tag, m_out, m_busy, m_ready);
    end
  endtask

  task automatic test_reset;
    reset = 1'b0;
    drive(0, 1'b0, 16'h0); drive(1, 1'b0, 16'h0); drive(2, 1'b0, 16'h0);
    repeat (3) @(posedge clk);
    #1;
    for (int s = 0; s < 3; s++) begin
      sel = s; #1;
      n_cmp++;
      if (m_out !== 1'b1 || m_busy !== 1'b0 || m_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL reset_hold dut%0d: out/busy/ready=%b%b%b required 101", s, m_out, m_busy, m_ready);
      end
    end
    reset = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      for (int s = 0; s < 3; s++) begin
        sel = s; #1;
        n_cmp++;
        if (m_out !== 1'b1 || m_busy !== 1'b0 || m_ready !== 1'b1) begin
          n_fail++;
          $display("FAIL reset_release dut%0d: out/busy/ready=%b%b%b required 101", s, m_out, m_busy, m_ready);
        end
      end
    end
    sel = 0;
  endtask

  task automatic test_single;
    tx_frame(0, 16'h00A5, 8, 4, 0, "single_a5");
    @(posedge clk); #1;
  endtask

  task automatic test_parity;
    tx_frame(1, 16'h0007, 8, 4, 1, "parity_07");
    @(posedge clk); #1;
    tx_frame(1, 16'h0003, 8, 4, 1, "parity_03");
    @(posedge clk); #1;
  endtask

  task automatic test_cpb1;
    tx_frame(2, 16'h0009, 4, 1, 0, "cpb1_9");
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back;
    sel = 0;
    model_frame(16'h0055, 8, 4, 0);
    a_valid = 1'b1; a_data = 8'h55;
    @(posedge clk); #1;
    a_data = 8'hFF;
    foreach (exp_q[i]) begin
      n_cmp++;
      if (m_out !== exp_q[i]) begin
        n_fail++;
        $display("FAIL b2b_first clk %0d: tx_out=%b required %b", i, m_out, exp_q[i]);
      end
      @(posedge clk); #1;
    end
    n_cmp++;
    if (m_out !== 1'b1 || m_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_gap: out/ready=%b%b required 11", m_out, m_ready);
    end
    model_frame(16'h00FF, 8, 4, 0);
    @(posedge clk); #1;
    a_valid = 1'b0;
    foreach (exp_q[i]) begin
      n_cmp++;
      if (m_out !== exp_q[i] || m_busy !== 1'b1) begin
        n_fail++;
        $display("FAIL b2b_second clk %0d: out/busy=%b%b required %b1", i, m_out, m_busy, exp_q[i]);
      end
      @(posedge clk); #1;
    end
    n_cmp++;
    if (m_out !== 1'b1 || m_ready !== 1'b1 || m_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_end: out/busy/ready=%b%b%b required 101", m_out, m_busy, m_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_frame;
    sel = 0;
    drive(0, 1'b1, 16'h0000);
    @(posedge clk); #1;
    drive(0, 1'b0, 16'h0000);
    repeat (17) @(posedge clk);
    #1;
    n_cmp++;
    if (m_out !== 1'b0 || m_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_pre: out/busy=%b%b required 01", m_out, m_busy);
    end
    reset = 1'b0;
    #1;
    n_cmp++;
    if (m_out !== 1'b1 || m_busy !== 1'b0 || m_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_async: out/busy/ready=%b%b%b required 101", m_out, m_busy, m_ready);
    end
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    tx_frame(0, 16'h0081, 8, 4, 0, "midrst_81");
    @(posedge clk); #1;
  endtask

  task automatic test_random;
    logic [15:0] d;
    for (int n = 0; n < 6; n++) begin
      d = 16'($urandom);
      tx_frame(0, d, 8, 4, 0, "rand_a");
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      d = 16'($urandom);
      tx_frame(1, d, 8, 4, 1, "rand_b");
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      d = 16'($urandom);
      tx_frame(2, {12'h000, d[3:0]}, 4, 1, 0, "rand_c");
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_parity();
    test_cpb1();
    test_back_to_back();
    test_reset_mid_frame();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
